// File: rtl/vs10xx_spi_responder.sv
// VS10xx decoder end of the MP3 serial link: SCI register file, SDI byte FIFO
// and DREQ flow control, all sampled through synchronizers into mp3_clk.
module vs10xx_spi_responder #(
    parameter int FIFO_DEPTH      = 64,
    parameter int DREQ_FREE       = 32,
    parameter int SCI_BUSY_CYCLES = 16,
    parameter int BOOT_CYCLES     = 64
) (
    input  logic        mp3_clk,
    input  logic        RST,
    input  logic        RSET,
    input  logic        XCS,
    input  logic        XDCS,
    input  logic        SCLK,
    input  logic        SI,
    output logic        SO,
    output logic        DREQ,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [15:0] sci_mode,
    output logic [15:0] sci_vol,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int SW = $clog2(SCI_BUSY_CYCLES + 1);

    logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic          rset_s, xcs_s, xdcs_s, sclk_s, si_s;
    logic          sclk_prev_q, sclk_prev_d;
    logic          rise_q, rise_d, fall_q, fall_d, bit_q, bit_d;

    logic [4:0]    sci_cnt_q, sci_cnt_d;
    logic [30:0]   sci_sr_q, sci_sr_d;
    logic [31:0]   sci_next;
    logic [14:0]   rd_sr_q, rd_sr_d;
    logic          reading_q, reading_d;
    logic          so_q, so_d;
    logic [15:0]   regs_q [16];
    logic [15:0]   regs_d [16];

    logic [2:0]    sdi_cnt_q, sdi_cnt_d;
    logic [6:0]    sdi_sr_q, sdi_sr_d;
    logic [7:0]    sdi_next;
    logic          push_q, push_d;
    logic [7:0]    push_data_q, push_data_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    dout_q, dout_d;
    logic          overflow_q, overflow_d;
    logic          dreq_q, dreq_d;
    logic [BW-1:0] boot_q, boot_d;
    logic [SW-1:0] busy_q, busy_d;
    logic          pop, full, push_ok;

    assign rset_s = sync2_q[4];
    assign xcs_s  = sync2_q[3];
    assign xdcs_s = sync2_q[2];
    assign sclk_s = sync2_q[1];
    assign si_s   = sync2_q[0];

    always_comb begin
        sync1_d     = {RSET, XCS, XDCS, SCLK, SI};
        sync2_d     = sync1_q;
        sclk_prev_d = sclk_s;
        rise_d      = sclk_s & ~sclk_prev_q;
        fall_d      = ~sclk_s & sclk_prev_q;
        bit_d       = si_s;

        sci_cnt_d   = sci_cnt_q;
        sci_sr_d    = sci_sr_q;
        rd_sr_d     = rd_sr_q;
        reading_d   = reading_q;
        so_d        = so_q;
        regs_d      = regs_q;
        sdi_cnt_d   = sdi_cnt_q;
        sdi_sr_d    = sdi_sr_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        busy_d      = (busy_q != '0) ? busy_q - SW'(1) : '0;
        boot_d      = (boot_q != '0) ? boot_q - BW'(1) : '0;
        sci_next    = {sci_sr_q, bit_q};
        sdi_next    = {sdi_sr_q, bit_q};

        if (xcs_s) begin
            sci_cnt_d = '0;
            reading_d = 1'b0;
            so_d      = 1'b0;
        end else if (rise_q) begin
            sci_sr_d  = sci_next[30:0];
            sci_cnt_d = sci_cnt_q + 5'd1;
            if (sci_cnt_q == 5'd15 && sci_next[15:8] == 8'h03) begin
                rd_sr_d   = regs_q[sci_next[3:0]][14:0];
                so_d      = regs_q[sci_next[3:0]][15];
                reading_d = 1'b1;
            end
            if (sci_cnt_q == 5'd31) begin
                reading_d = 1'b0;
                so_d      = 1'b0;
                if (sci_next[31:24] == 8'h02) begin
                    regs_d[sci_next[19:16]] = sci_next[15:0];
                    busy_d = SW'(SCI_BUSY_CYCLES);
                end
            end
        end else if (fall_q && reading_q && sci_cnt_q >= 5'd17) begin
            // The fall right after the 16th bit leaves the MSB in place for bit 17.
            so_d    = rd_sr_q[14];
            rd_sr_d = {rd_sr_q[13:0], 1'b0};
        end

        if (!xcs_s || xdcs_s) begin
            sdi_cnt_d = '0;
        end else if (rise_q) begin
            sdi_sr_d  = sdi_next[6:0];
            sdi_cnt_d = sdi_cnt_q + 3'd1;
            if (sdi_cnt_q == 3'd7) begin
                push_d      = 1'b1;
                push_data_d = sdi_next;
            end
        end

        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = (count_q != '0) && dout_ready;
        push_ok = push_q && (!full || pop);
        if (push_q && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A byte landing in an empty slot is not in mem_q yet, so forward it.
        if (count_d == '0) begin
            dout_d = 8'h00;
        end else if (push_ok && rd_ptr_d == wr_ptr_q) begin
            dout_d = push_data_q;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end

        dreq_d = (boot_d == '0) && (busy_d == '0) &&
                 ((CW'(FIFO_DEPTH) - count_q) >= CW'(DREQ_FREE));

        if (!rset_s) begin
            sci_cnt_d   = '0;
            sci_sr_d    = '0;
            rd_sr_d     = '0;
            reading_d   = 1'b0;
            so_d        = 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_d[i] = (i == 0) ? 16'h0800 : 16'h0000;
            end
            sdi_cnt_d   = '0;
            sdi_sr_d    = '0;
            push_d      = 1'b0;
            push_data_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            dout_d      = 8'h00;
            dreq_d      = 1'b0;
            boot_d      = BW'(BOOT_CYCLES);
            busy_d      = '0;
        end
    end

    always_ff @(posedge mp3_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge mp3_clk) begin
        if (!RST) begin
            sync1_q     <= 5'b11100;
            sync2_q     <= 5'b11100;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            bit_q       <= 1'b0;
            sci_cnt_q   <= '0;
            sci_sr_q    <= '0;
            rd_sr_q     <= '0;
            reading_q   <= 1'b0;
            so_q        <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= (i == 0) ? 16'h0800 : 16'h0000;
            end
            sdi_cnt_q   <= '0;
            sdi_sr_q    <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= 8'h00;
            overflow_q  <= 1'b0;
            dreq_q      <= 1'b0;
            boot_q      <= BW'(BOOT_CYCLES);
            busy_q      <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sclk_prev_q <= sclk_prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            bit_q       <= bit_d;
            sci_cnt_q   <= sci_cnt_d;
            sci_sr_q    <= sci_sr_d;
            rd_sr_q     <= rd_sr_d;
            reading_q   <= reading_d;
            so_q        <= so_d;
            regs_q      <= regs_d;
            sdi_cnt_q   <= sdi_cnt_d;
            sdi_sr_q    <= sdi_sr_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            dreq_q      <= dreq_d;
            boot_q      <= boot_d;
            busy_q      <= busy_d;
        end
    end

    assign SO         = so_q;
    assign DREQ       = dreq_q;
    assign dout       = dout_q;
    assign dout_valid = (count_q != '0);
    assign sci_mode   = regs_q[0];
    assign sci_vol    = regs_q[11];
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_vs10xx_spi_responder.sv
// Directed bench for vs10xx_spi_responder: SCI/SDI frames driven bit by bit,
// FIFO bytes checked through a scoreboard queue by an independent monitor.
module tb_vs10xx_spi_responder;

    localparam int FIFO_DEPTH = 64;
    localparam int BOOT       = 64;
    localparam int HALF       = 6;

    logic        mp3_clk = 1'b0;
    logic        RST, RSET, XCS, XDCS, SCLK, SI, dout_ready;
    logic        SO, DREQ, dout_valid, overflow;
    logic [7:0]  dout;
    logic [15:0] sci_mode, sci_vol;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    logic [15:0] rd;
    int          n;
    int          model;
    logic [7:0]  byte_v;

    vs10xx_spi_responder #(
        .FIFO_DEPTH(FIFO_DEPTH), .DREQ_FREE(32), .SCI_BUSY_CYCLES(16), .BOOT_CYCLES(BOOT)
    ) dut (
        .mp3_clk(mp3_clk), .RST(RST), .RSET(RSET), .XCS(XCS), .XDCS(XDCS),
        .SCLK(SCLK), .SI(SI), .SO(SO), .DREQ(DREQ), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .sci_mode(sci_mode), .sci_vol(sci_vol), .overflow(overflow)
    );

    always #5 mp3_clk = ~mp3_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every byte the consumer takes must be the next one the stimulus queued.
    always @(negedge mp3_clk) begin
        if (RST && dout_valid && dout_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL sdi_byte: got %02h expected <none queued>", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dout !== mon_exp) begin
                    miscompares++;
                    $display("[TB] FAIL sdi_byte: got %02h expected %02h", dout, mon_exp);
                end
            end
        end
    end

    task automatic waitClocks(input int cycles);
        repeat (cycles) @(posedge mp3_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitDreq(output int cycles);
        cycles = 0;
        while (DREQ !== 1'b1 && cycles < 500) begin
            waitClocks(1);
            cycles++;
        end
    endtask

    // Shifts nbits of word (MSB = bit width-1) under XCS or XDCS, capturing SO.
    task automatic applyStimulus(input logic [31:0] word, input int width, input int nbits,
                                 input bit is_sci, output logic [15:0] so_word);
        so_word = '0;
        if (is_sci) XCS = 1'b0;
        else        XDCS = 1'b0;
        waitClocks(HALF);
        for (int i = 0; i < nbits; i++) begin
            SI = word[width-1-i];
            waitClocks(HALF);
            if (is_sci && i >= 16 && i < 32) so_word[31-i] = SO;
            SCLK = 1'b1;
            waitClocks(HALF);
            SCLK = 1'b0;
        end
        waitClocks(HALF);
        if (is_sci) XCS = 1'b1;
        else        XDCS = 1'b1;
        waitClocks(4);
    endtask

    initial begin
        RST = 1'b0; RSET = 1'b1; XCS = 1'b1; XDCS = 1'b1;
        SCLK = 1'b0; SI = 1'b0; dout_ready = 1'b1;
        waitClocks(5);
        checkOutput("rst_so", SO, 0);
        checkOutput("rst_dreq", DREQ, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_dout_valid", dout_valid, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_mode", sci_mode, 16'h0800);
        checkOutput("rst_vol", sci_vol, 16'h0000);
        RST = 1'b1;
        waitDreq(n);
        checkOutput("dreq_after_rst", DREQ, 1);

        RSET = 1'b0;
        waitClocks(10);
        checkOutput("rset_dreq_low", DREQ, 0);
        RSET = 1'b1;
        waitDreq(n);
        vectors++;
        if (n < BOOT + 1 || n > BOOT + 4) begin
            miscompares++;
            $display("[TB] FAIL boot_len: got %0d cycles expected %0d..%0d", n, BOOT + 1, BOOT + 4);
        end
        checkOutput("boot_mode", sci_mode, 16'h0800);

        applyStimulus(32'h02000804, 32, 32, 1'b1, rd);
        checkOutput("busy_dreq_low", DREQ, 0);
        waitClocks(6);
        checkOutput("busy_dreq_high", DREQ, 1);
        applyStimulus(32'h020B0000, 32, 32, 1'b1, rd);
        checkOutput("busy2_dreq_low", DREQ, 0);
        waitClocks(6);
        checkOutput("busy2_dreq_high", DREQ, 1);
        checkOutput("mode_0804", sci_mode, 16'h0804);
        checkOutput("vol_0000", sci_vol, 16'h0000);

        applyStimulus(32'h0203ABCD, 32, 32, 1'b1, rd);
        applyStimulus(32'h03030000, 32, 32, 1'b1, rd);
        checkOutput("read_reg3", rd, 16'hABCD);
        checkOutput("so_idle", SO, 0);

        applyStimulus(32'h02001234, 32, 20, 1'b1, rd);
        checkOutput("abort_mode", sci_mode, 16'h0804);
        applyStimulus(32'h04001234, 32, 32, 1'b1, rd);
        checkOutput("ignored_op_mode", sci_mode, 16'h0804);
        applyStimulus(32'h02005A5A, 32, 32, 1'b1, rd);
        checkOutput("mode_after_abort", sci_mode, 16'h5A5A);
        applyStimulus(32'h03000000, 32, 32, 1'b1, rd);
        checkOutput("read_mode", rd, 16'h5A5A);
        applyStimulus(32'h02FB1111, 32, 32, 1'b1, rd);
        checkOutput("vol_high_addr", sci_vol, 16'h1111);

        XDCS = 1'b0;
        applyStimulus(32'h020B00FF, 32, 32, 1'b1, rd);
        XDCS = 1'b1;
        waitClocks(4);
        checkOutput("vol_sci_priority", sci_vol, 16'h00FF);

        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        applyStimulus(32'h1234, 16, 16, 1'b0, rd);
        exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        applyStimulus(32'h5678, 16, 16, 1'b0, rd);
        applyStimulus(32'h1F, 5, 5, 1'b0, rd);
        exp_q.push_back(8'hA5);
        applyStimulus(32'hA5, 8, 8, 1'b0, rd);
        waitClocks(10);
        checkOutput("sdi_queue_drained", exp_q.size(), 0);
        checkOutput("sdi_empty", dout_valid, 0);
        checkOutput("sdi_no_overflow", overflow, 0);

        dout_ready = 1'b0;
        model = 0;
        for (int b = 1; b <= 65; b++) begin
            byte_v = 8'(b);
            if (model < FIFO_DEPTH) begin
                exp_q.push_back(byte_v);
                model++;
            end
            applyStimulus({24'h0, byte_v}, 8, 8, 1'b0, rd);
            if (b == 32) checkOutput("dreq_at_32", DREQ, 1);
            if (b == 33) checkOutput("dreq_at_33", DREQ, 0);
            if (b == 64) checkOutput("overflow_at_64", overflow, 0);
            if (b == 65) begin
                checkOutput("overflow_at_65", overflow, 1);
                checkOutput("valid_at_65", dout_valid, 1);
                checkOutput("head_at_65", dout, 8'h01);
            end
        end
        dout_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            waitClocks(1);
            n++;
        end
        waitClocks(3);
        checkOutput("fifo_drained", exp_q.size(), 0);
        checkOutput("fifo_empty", dout_valid, 0);
        checkOutput("dreq_after_drain", DREQ, 1);

        dout_ready = 1'b0;
        applyStimulus(32'h77, 8, 8, 1'b0, rd);
        checkOutput("held_valid", dout_valid, 1);
        checkOutput("held_dout", dout, 8'h77);
        RSET = 1'b0;
        waitClocks(10);
        checkOutput("rset_keeps_overflow", overflow, 1);
        checkOutput("rset_clears_fifo", dout_valid, 0);
        checkOutput("rset_mode", sci_mode, 16'h0800);
        checkOutput("rset_vol", sci_vol, 16'h0000);
        RSET = 1'b1;
        waitDreq(n);
        checkOutput("dreq_after_rset", DREQ, 1);
        dout_ready = 1'b1;

        RST = 1'b0;
        waitClocks(3);
        checkOutput("rst_clears_overflow", overflow, 0);
        RST = 1'b1;
        waitClocks(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
